// File: rtl/mcs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcs_pkg
//  Description : Shared constants for the p32 multiplier-column sequencer:
//                field width, column geometry, derived bus widths and the
//                sequencer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package mcs_pkg;

    localparam int M            = 13;
    localparam int PROD_PER_COL = 8;
    localparam int NUM_COLS     = 4;

    localparam int COL_W = PROD_PER_COL * M;
    localparam int OUT_W = NUM_COLS * COL_W;

    // Group index width; sized for NUM_COLS = 4.
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t LAST_SEL = sel_t'(NUM_COLS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

endpackage : mcs_pkg
`default_nettype wire

// File: rtl/mcs_capture_bank.sv
`default_nettype none
// ============================================================================
//  Module      : mcs_capture_bank
//  Description : NUM_COLS x COL_W register bank. One group is written per
//                cycle, selected by sel_i, and the whole bank is presented
//                as one flat product word.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk    in   system clock, rising edge
//    rst_n  in   asynchronous active-low reset, clears every group
//    we_i   in   write enable
//    sel_i  in   group index to write
//    d_i    in   COL_W column products for the selected group
//    q_o    out  OUT_W flat word, group g at q_o[g*COL_W +: COL_W]
// ============================================================================
module mcs_capture_bank
    import mcs_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [SEL_W-1:0] sel_i,
    input  logic [COL_W-1:0] d_i,
    output logic [OUT_W-1:0] q_o
);

    for (genvar g = 0; g < NUM_COLS; g++) begin : g_group
        logic [COL_W-1:0] grp_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                grp_q <= '0;
            end else if (we_i && (sel_i == SEL_W'(g))) begin
                grp_q <= d_i;
            end
        end

        assign q_o[g*COL_W +: COL_W] = grp_q;
    end

endmodule : mcs_capture_bank
`default_nettype wire

// File: rtl/mult_column_sched_p32.sv
`default_nettype none
// ============================================================================
//  Module      : mult_column_sched_p32
//  Description : Shares one 8-output GF(2^13) constant-multiplier column
//                across the 32 products of the p32 BCH datapath. An operand
//                accepted over valid/ready is held on col_b while col_sel
//                walks the NUM_COLS constant banks, one per cycle; each
//                group of 8 products is captured and the full 32-product
//                word is offered downstream over valid/ready.
//  Revision    : 1.0  initial release
//
//  Build option
//    MCS_OVERLAP_EN  when defined, a new operand may be accepted in HOLD
//                    in the same cycle the product word is taken, going
//                    straight back to RUN (initiation interval NUM_COLS+1
//                    instead of NUM_COLS+2).
//
//  Ports
//    clk        in   system clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    in_valid   in   operand valid
//    in_ready   out  operand accepted when in_valid && in_ready
//    in_b       in   field element to multiply
//    col_b      out  operand to the multiplier column (registered)
//    col_sel    out  constant-bank select 0..NUM_COLS-1 (registered)
//    col_p      in   combinational column products for col_b/col_sel
//    out_valid  out  product word valid
//    out_ready  in   downstream accept
//    out_p      out  32 products, product k at out_p[k*M +: M]
//    busy       out  high in RUN or HOLD
// ============================================================================
module mult_column_sched_p32
    import mcs_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M-1:0]     in_b,
    output logic [M-1:0]     col_b,
    output logic [1:0]       col_sel,
    input  logic [COL_W-1:0] col_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_p,
    output logic             busy
);

    logic [1:0]       state_q,     state_d;
    logic [SEL_W-1:0] cnt_q,       cnt_d;
    logic [M-1:0]     col_b_q,     col_b_d;
    logic [SEL_W-1:0] col_sel_q,   col_sel_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             capture_en;

`ifdef MCS_OVERLAP_EN
    // In HOLD, a free slot exists only if the current word leaves this cycle.
    assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
`else
    assign in_ready = (state_q == IDLE);
`endif

    assign accept     = in_valid && in_ready;
    assign capture_en = (state_q == RUN);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_b_d     = col_b_q;
        col_sel_d   = col_sel_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    col_b_d   = in_b;
                    col_sel_d = '0;
                    cnt_d     = '0;
                    state_d   = RUN;
                end
            end

            RUN: begin
                if (cnt_q == LAST_SEL) begin
                    // Last group is captured on this edge, so the word
                    // becomes valid together with it.
                    state_d     = HOLD;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    col_sel_d = cnt_q + 1'b1;
                end
            end

            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    col_sel_d   = '0;
                    state_d     = IDLE;
`ifdef MCS_OVERLAP_EN
                    if (accept) begin
                        col_b_d = in_b;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            col_b_q     <= '0;
            col_sel_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_b_q     <= col_b_d;
            col_sel_q   <= col_sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    mcs_capture_bank u_capture_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .we_i  (capture_en),
        .sel_i (cnt_q),
        .d_i   (col_p),
        .q_o   (out_p)
    );

    assign col_b     = col_b_q;
    assign col_sel   = col_sel_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);

endmodule : mult_column_sched_p32
`default_nettype wire

// File: tb/tb_mult_column_sched_p32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_column_sched_p32
//  Description : Self-checking bench for mult_column_sched_p32. A column
//                model drives col_p either with a fixed pattern
//                (13'h0100 + col_sel in every slot) or as a real GF(2^13)
//                constant column where product k = b * alpha^(k+1).
//                Expected words come from a reference model computed
//                directly from that product definition.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mult_column_sched_p32;

    localparam int TM     = 13;
    localparam int TCOL_W = 104;
    localparam int TOUT_W = 416;

`ifdef MCS_OVERLAP_EN
    localparam int EXP_II = 5;
`else
    localparam int EXP_II = 6;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [TM-1:0]     in_b;
    logic [TM-1:0]     col_b;
    logic [1:0]        col_sel;
    logic [TCOL_W-1:0] col_p;
    logic              out_valid;
    logic              out_ready;
    logic [TOUT_W-1:0] out_p;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;
    bit col_mode = 1'b0;   // 0: fixed pattern column, 1: GF multiplier column

    always #5 clk = ~clk;

    mult_column_sched_p32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_b      (in_b),
        .col_b     (col_b),
        .col_sel   (col_sel),
        .col_p     (col_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    // ---------------- GF(2^13), x^13 + x^4 + x^3 + x + 1 ----------------
    function automatic logic [12:0] xtime(input logic [12:0] a);
        return {a[11:0], 1'b0} ^ (a[12] ? 13'h001B : 13'h0000);
    endfunction

    function automatic logic [12:0] gf_mul(input logic [12:0] a, input logic [12:0] b);
        logic [12:0] r;
        r = '0;
        for (int i = 12; i >= 0; i--) begin
            r = xtime(r);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    function automatic logic [12:0] alpha_pow(input int n);
        logic [12:0] r;
        r = 13'h0001;
        for (int i = 0; i < n; i++) r = xtime(r);
        return r;
    endfunction

    // Reference word: product k of the 32 for operand b.
    function automatic logic [TOUT_W-1:0] model_word(input logic [12:0] b, input bit mode);
        logic [TOUT_W-1:0] w;
        w = '0;
        for (int k = 0; k < 32; k++) begin
            if (mode) w[k*13 +: 13] = gf_mul(b, alpha_pow(k + 1));
            else      w[k*13 +: 13] = 13'h0100 + 13'(k / 8);
        end
        return w;
    endfunction

    // Column model: purely combinational in col_b/col_sel.
    always_comb begin
        col_p = '0;
        for (int j = 0; j < 8; j++) begin
            if (col_mode) col_p[j*13 +: 13] = gf_mul(col_b, alpha_pow(int'(col_sel) * 8 + j + 1));
            else          col_p[j*13 +: 13] = 13'h0100 + {11'b0, col_sel};
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic start_txn(input logic [12:0] b);
        in_valid = 1'b1;
        in_b     = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic take_word();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_b = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (col_b !== 13'h0) $display("FAIL reset_col_b: got %h expected 0", col_b); else n_pass++;
        n_checks++; if (col_sel !== 2'd0) $display("FAIL reset_col_sel: got %0d expected 0", col_sel); else n_pass++;
        n_checks++; if (out_p !== '0) $display("FAIL reset_out_p: got %h expected 0", out_p); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_single();
        logic [TOUT_W-1:0] exp_w;
        col_mode = 1'b0;
        exp_w = model_word(13'h0001, 1'b0);
        start_txn(13'h0001);
        n_checks++; if (col_b !== 13'h0001) $display("FAIL single_col_b: got %h expected 0001", col_b); else n_pass++;
        n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL single_run_flags: got ready=%b busy=%b expected ready=0 busy=1", in_ready, busy); else n_pass++;
        // col_sel seen before each of the four capture edges
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (col_sel !== 2'(i)) $display("FAIL single_col_sel_%0d: got %0d expected %0d", i, col_sel, i); else n_pass++;
            n_checks++; if (out_valid !== 1'b0) $display("FAIL single_early_valid_%0d: got %b expected 0", i, out_valid); else n_pass++;
            @(posedge clk); #1;
        end
        n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid_T4: got %b expected 1", out_valid); else n_pass++;
        n_checks++; if (out_p !== exp_w) $display("FAIL single_out_p: got %h expected %h", out_p, exp_w); else n_pass++;
        take_word();
        n_checks++; if (out_valid !== 1'b0 || col_sel !== 2'd0 || busy !== 1'b0)
            $display("FAIL single_after_take: got valid=%b sel=%0d busy=%b expected 0 0 0", out_valid, col_sel, busy); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [TOUT_W-1:0] exp_a, exp_b;
        int lat;
        col_mode = 1'b1;
        exp_a = model_word(13'h0777, 1'b1);
        exp_b = model_word(13'h1ABC, 1'b1);
        start_txn(13'h0777);
        wait_valid(lat);
        n_checks++; if (lat != 4) $display("FAIL bp_latency: got %0d expected 4", lat); else n_pass++;
        in_valid = 1'b1; in_b = 13'h1ABC; out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid_%0d: got %b expected 1", c, out_valid); else n_pass++;
            n_checks++; if (out_p !== exp_a) $display("FAIL bp_hold_out_p_%0d: got %h expected %h", c, out_p, exp_a); else n_pass++;
            n_checks++; if (in_ready !== 1'b0 || col_b !== 13'h0777)
                $display("FAIL bp_hold_in_%0d: got ready=%b col_b=%h expected 0 0777", c, in_ready, col_b); else n_pass++;
        end
        take_word();
`ifdef MCS_OVERLAP_EN
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b1 || col_b !== 13'h1ABC)
            $display("FAIL bp_overlap_load: got valid=%b busy=%b col_b=%h expected 0 1 1abc", out_valid, busy, col_b); else n_pass++;
`else
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || col_b !== 13'h0777)
            $display("FAIL bp_idle: got valid=%b busy=%b ready=%b col_b=%h expected 0 0 1 0777", out_valid, busy, in_ready, col_b); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b1 || col_b !== 13'h1ABC)
            $display("FAIL bp_accept_idle: got busy=%b col_b=%h expected 1 1abc", busy, col_b); else n_pass++;
`endif
        in_valid = 1'b0;
        wait_valid(lat);
        n_checks++; if (lat < 0) $display("FAIL bp_second_timeout: got no out_valid expected one"); else n_pass++;
        n_checks++; if (out_p !== exp_b) $display("FAIL bp_second_out_p: got %h expected %h", out_p, exp_b); else n_pass++;
        take_word();
    endtask

    task automatic test_async_reset();
        logic [TOUT_W-1:0] exp_w;
        int lat;
        bit seen;
        col_mode = 1'b1;
        start_txn(13'h0ABC);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (col_sel == 2'd2) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_checks++; if (!seen) $display("FAIL arst_reach_sel2: got col_sel=%0d expected 2", col_sel); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL arst_flags: got valid=%b busy=%b ready=%b expected 0 0 1", out_valid, busy, in_ready); else n_pass++;
        n_checks++; if (col_b !== 13'h0 || col_sel !== 2'd0)
            $display("FAIL arst_col: got col_b=%h sel=%0d expected 0 0", col_b, col_sel); else n_pass++;
        n_checks++; if (out_p !== '0) $display("FAIL arst_out_p: got %h expected 0", out_p); else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        exp_w = model_word(13'h0005, 1'b1);
        start_txn(13'h0005);
        wait_valid(lat);
        n_checks++; if (lat != 4) $display("FAIL arst_next_latency: got %0d expected 4", lat); else n_pass++;
        n_checks++; if (out_p !== exp_w) $display("FAIL arst_next_out_p: got %h expected %h", out_p, exp_w); else n_pass++;
        take_word();
    endtask

    task automatic test_zero();
        int lat;
        col_mode = 1'b1;
        start_txn(13'h0000);
        wait_valid(lat);
        n_checks++; if (lat != 4) $display("FAIL zero_latency: got %0d expected 4", lat); else n_pass++;
        n_checks++; if (out_p !== '0) $display("FAIL zero_out_p: got %h expected 0", out_p); else n_pass++;
        take_word();
    endtask

    task automatic test_back_to_back();
        logic [12:0] ops [3];
        int tv [3];
        int idx, nv, cyc;
        bit acc;
        logic [TOUT_W-1:0] exp_w;
        col_mode = 1'b1;
        ops[0] = 13'h0001; ops[1] = 13'h0002; ops[2] = 13'h0003;
        idx = 0; nv = 0; cyc = 0;
        in_valid = 1'b1; in_b = ops[0]; out_ready = 1'b1;
        while (nv < 3 && cyc < 100) begin
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 3) in_b = ops[idx];
                else         in_valid = 1'b0;
            end
            if (out_valid) begin
                exp_w = model_word(ops[nv], 1'b1);
                n_checks++; if (out_p !== exp_w) $display("FAIL b2b_word_%0d: got %h expected %h", nv, out_p, exp_w); else n_pass++;
                tv[nv] = cyc;
                nv++;
            end
        end
        n_checks++; if (nv != 3) $display("FAIL b2b_timeout: got %0d words expected 3", nv); else n_pass++;
        if (nv == 3) begin
            n_checks++; if (tv[1] - tv[0] != EXP_II) $display("FAIL b2b_ii_0: got %0d expected %0d", tv[1] - tv[0], EXP_II); else n_pass++;
            n_checks++; if (tv[2] - tv[1] != EXP_II) $display("FAIL b2b_ii_1: got %0d expected %0d", tv[2] - tv[1], EXP_II); else n_pass++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [TOUT_W-1:0] exp_q [$];
        logic [TOUT_W-1:0] exp_w;
        int sent, got, cyc;
        bit acc;
        localparam int N = 16;
        col_mode = 1'b1;
        sent = 0; got = 0; cyc = 0;
        in_valid = 1'b0; out_ready = 1'b0;
        while (got < N && cyc < 3000) begin
            if (!in_valid && sent < N && $urandom_range(0, 2) != 0) begin
                in_valid = 1'b1;
                in_b     = 13'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rand_unexpected_word: got %h expected none", out_p);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (out_p !== exp_w) $display("FAIL rand_word_%0d: got %h expected %h", got, out_p, exp_w);
                    else n_pass++;
                end
                got++;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                exp_q.push_back(model_word(in_b, 1'b1));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (sent < N && $urandom_range(0, 1) != 0) in_b = 13'($urandom);
                else in_valid = 1'b0;
            end
        end
        n_checks++; if (got != N) $display("FAIL rand_timeout: got %0d words expected %0d", got, N); else n_pass++;
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_async_reset();
        test_zero();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mult_column_sched_p32
`default_nettype wire
